// File: rtl/latch_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : latch_bank_pkg
// Description : Shared types and helpers for the latch_bank channel bank.
//               - latch_act_e   : resolved per-channel latch action
//               - resolve_act() : clear > set > toggle priority resolution
//               - dbc_width()   : debounce counter width for a cycle count
// Revision    : 1.0 - initial release
// ============================================================================
package latch_bank_pkg;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_CLR  = 2'd1,
        ACT_SET  = 2'd2,
        ACT_TOG  = 2'd3
    } latch_act_e;

    // Clear dominates set, set dominates toggle.
    function automatic latch_act_e resolve_act(input logic i_clr,
                                               input logic i_set,
                                               input logic i_tog);
        if (i_clr)      return ACT_CLR;
        else if (i_set) return ACT_SET;
        else if (i_tog) return ACT_TOG;
        else            return ACT_NONE;
    endfunction

    // Counter must be able to hold the value DebounceCycles.
    function automatic int dbc_width(input int i_cycles);
        return (i_cycles < 1) ? 1 : $clog2(i_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
// Module      : debounce_sync
// Description : One raw input bit: synchroniser chain, debounce filter and
//               rising-edge detector on the debounced level.
// Ports       : clk_i    - clock, rising edge
//               reset_ni - synchronous active-low reset
//               i_raw    - raw asynchronous input bit
//               o_act    - one-cycle pulse on a debounced rising level
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_sync
    import latch_bank_pkg::*;
#(
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 4
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic i_raw,
    output logic o_act
);

    localparam int                c_cnt_w    = dbc_width(DebounceCycles);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DebounceCycles - 1);

    logic [SyncStages-1:0] r_sync;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_stable;
    logic                  r_stable_q;
    logic                  w_synced;

    assign w_synced = r_sync[SyncStages-1];

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SyncStages-2:0], i_raw};
            r_stable_q <= r_stable;
            if (w_synced == r_stable) begin
                // Any return to the accepted level restarts the count.
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                // This edge makes DebounceCycles differing samples: accept.
                r_stable <= w_synced;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign o_act = r_stable & ~r_stable_q;

endmodule
`default_nettype wire

// File: rtl/latch_bank.sv
`default_nettype none
// ============================================================================
// Module      : latch_bank
// Description : Bank of Channels independent set/clear/toggle latches fed by
//               synchronised, debounced raw inputs, with registered
//               rise/fall event pulses per channel.
// Ports       : clk_i    - clock, rising edge
//               reset_ni - synchronous active-low reset
//               set_i    - raw set requests, one per channel
//               clr_i    - raw clear requests, one per channel
//               tog_i    - raw toggle requests, one per channel
//               d_o      - latched channel state
//               rise_o   - one-cycle pulse on first cycle d_o[n] is 1
//               fall_o   - one-cycle pulse on first cycle d_o[n] is 0
// Revision    : 1.0 - initial release
// ============================================================================
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int Channels       = 4,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 4
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [Channels-1:0] set_i,
    input  logic [Channels-1:0] clr_i,
    input  logic [Channels-1:0] tog_i,
    output logic [Channels-1:0] d_o,
    output logic [Channels-1:0] rise_o,
    output logic [Channels-1:0] fall_o
);

    localparam int c_paths = 3 * Channels;

    // Path layout: [Channels-1:0] clear, then set, then toggle.
    logic [c_paths-1:0]  w_raw;
    logic [c_paths-1:0]  w_act;
    logic [Channels-1:0] w_next;
    logic [Channels-1:0] r_d;
    logic [Channels-1:0] r_rise;
    logic [Channels-1:0] r_fall;

    assign w_raw = {tog_i, set_i, clr_i};

    generate
        for (genvar p = 0; p < c_paths; p++) begin : g_path
            debounce_sync #(
                .SyncStages     (SyncStages),
                .DebounceCycles (DebounceCycles)
            ) u_debounce_sync (
                .clk_i    (clk_i),
                .reset_ni (reset_ni),
                .i_raw    (w_raw[p]),
                .o_act    (w_act[p])
            );
        end
    endgenerate

    always_comb begin
        w_next = r_d;
        for (int ch = 0; ch < Channels; ch++) begin
            case (resolve_act(w_act[ch], w_act[Channels + ch],
                              w_act[2*Channels + ch]))
                ACT_CLR: w_next[ch] = 1'b0;
                ACT_SET: w_next[ch] = 1'b1;
                ACT_TOG: w_next[ch] = ~r_d[ch];
                default: w_next[ch] = r_d[ch];
            endcase
        end
    end

    // Pulses come from next-vs-current so they align with the new level.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_d    <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_d    <= w_next;
            r_rise <= w_next & ~r_d;
            r_fall <= ~w_next & r_d;
        end
    end

    assign d_o    = r_d;
    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule
`default_nettype wire
